// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin arbitration with a message lock, 8N1 framing.
// Define UART_TX_ARBITER_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_arbiter #(
  parameter int unsigned CLK_HZ = 27000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_ARBITER_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             last_q;
  logic             ptr;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic             bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      uart_tx    <= 1'b1;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            if (req1_valid && (!req0_valid || ptr)) begin
              grant      <= 2'b10;
              req1_ready <= 1'b1;
            end else begin
              grant      <= 2'b01;
              req0_ready <= 1'b1;
            end
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        // Owner keeps the line until its last byte; a stalled owner just holds here.
        LOAD: begin
          if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            data_q     <= grant[0] ? req0_data : req1_data;
            last_q     <= grant[0] ? req0_last : req1_last;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            uart_tx    <= 1'b0;
            cnt        <= '0;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            uart_tx <= data_q[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_ARBITER_PARITY_EN
              uart_tx <= ^data_q;
              state   <= PARITY;
`else
              uart_tx <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= data_q[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_ARBITER_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            uart_tx <= 1'b1;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_q) begin
              grant <= 2'b00;
              busy  <= 1'b0;
              ptr   <= grant[0];
              state <= IDLE;
            end else begin
              req0_ready <= grant[0];
              req1_ready <= grant[1];
              state      <= LOAD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          uart_tx    <= 1'b1;
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          grant      <= 2'b00;
          busy       <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at CLKS_PER_BIT=16: serial-line monitor against a scoreboard of expected bytes.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int NBITS    = 11;
  localparam int NFRAMES  = 15;
`else
  localparam int NBITS    = 10;
  localparam int NFRAMES  = 13;
`endif
  localparam int CPB      = 16;
  localparam int FRAME    = NBITS * CPB;
  localparam int LIMIT    = 4000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] grant;
  logic       busy;
  logic       uart_tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_rx = 0;
  logic [8:0] sb[$];   // {owner, data}

  uart_tx_arbiter #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .grant(grant), .busy(busy), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offer one byte and return the cycle number of its transfer edge.
  task automatic send(input int id, input logic [7:0] d, input logic l, output int t);
    int n;
    logic rdy;
    n = 0;
    t = -1;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    else         begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    rdy = (id == 0) ? req0_ready : req1_ready;
    while (!rdy && n < LIMIT) begin
      @(negedge clk);
      n++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    check("handshake", 32'(n < LIMIT), 32'd1);
    if (n < LIMIT) begin
      @(posedge clk);
      t = cyc;
      #1;
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < LIMIT) begin @(negedge clk); n++; end
    check("idle_timeout", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
  endtask

  task automatic mon_wait(input int n, inout logic alive);
    for (int i = 0; i < n && alive; i++) begin
      @(negedge clk);
      if (!reset_n) alive = 1'b0;
    end
  endtask

  // Line monitor: decode each frame at mid-bit and compare with the scoreboard head.
  initial begin : monitor
    logic [NBITS-1:0] bits;
    logic owner, alive;
    logic [8:0] exp;
    forever begin
      do @(negedge clk); while (!(reset_n && !uart_tx));
      owner = grant[1];
      alive = 1'b1;
      bits = '0;
      for (int i = 0; i < NBITS; i++) begin
        mon_wait((i == 0) ? 7 : CPB, alive);
        bits[i] = uart_tx;
      end
      if (!alive) begin
        wait (reset_n);
      end else begin
        frames_rx++;
        check("start_bit", 32'(bits[0]), 32'd0);
        check("stop_bit", 32'(bits[NBITS-1]), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check("rx_data", 32'(bits[8:1]), 32'(exp[7:0]));
          check("rx_owner", 32'(owner), 32'(exp[8]));
`ifdef UART_TX_ARBITER_PARITY_EN
          check("rx_parity", 32'(bits[9]), 32'(^exp[7:0]));
`endif
        end
      end
    end
  end

  initial begin : stim
    int ta, tb, t1, t2, t3;
    // Reset values
    wait_neg(3);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy0", 32'(req0_ready), 32'd0);
    check("rst_rdy1", 32'(req1_ready), 32'd0);
    reset_n = 1'b1;
    wait_neg(2);
    check("idle_no_grant", 32'(grant), 32'd0);

    // Tie after reset: req0 first, then req1
    sb.push_back({1'b0, 8'hA1});
    sb.push_back({1'b1, 8'hB2});
    fork
      send(0, 8'hA1, 1'b1, ta);
      send(1, 8'hB2, 1'b1, tb);
      begin @(negedge clk); check("tie1_grant", 32'(grant), 32'd1); end
    join
    check("tie1_req1_xfer", 32'(tb - ta), 32'(FRAME + 2));
    wait_idle();

    // Next tie returns to req0
    sb.push_back({1'b0, 8'hC3});
    sb.push_back({1'b1, 8'hD4});
    fork
      send(0, 8'hC3, 1'b1, ta);
      send(1, 8'hD4, 1'b1, tb);
      begin @(negedge clk); check("tie2_grant", 32'(grant), 32'd1); end
    join
    wait_idle();

    // Lock: 3-byte req0 message while req1 waits
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h02});
    sb.push_back({1'b0, 8'h03});
    sb.push_back({1'b1, 8'h7E});
    fork
      begin
        send(0, 8'h01, 1'b0, t1);
        send(0, 8'h02, 1'b0, t2);
        send(0, 8'h03, 1'b1, t3);
      end
      send(1, 8'h7E, 1'b1, tb);
    join
    check("lock_gap1", 32'(t2 - t1), 32'(FRAME + 1));
    check("lock_gap2", 32'(t3 - t2), 32'(FRAME + 1));
    check("lock_req1_xfer", 32'(tb - t3), 32'(FRAME + 2));
    wait_idle();

    // Single byte 0x55 with latency and frame-length checks
    sb.push_back({1'b0, 8'h55});
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
    @(negedge clk);
    check("lat_grant", 32'(grant), 32'd1);
    check("lat_rdy0", 32'(req0_ready), 32'd1);
    check("lat_tx_high", 32'(uart_tx), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("lat_tx_low", 32'(uart_tx), 32'd0);
    check("lat_rdy0_pulse", 32'(req0_ready), 32'd0);
    wait_neg(FRAME - 1);
    check("frame_busy_end", 32'(busy), 32'd1);
    @(negedge clk);
    check("frame_idle_busy", 32'(busy), 32'd0);
    check("frame_idle_grant", 32'(grant), 32'd0);
    check("frame_idle_tx", 32'(uart_tx), 32'd1);

    // Stall: owner drops valid mid-message, req1 stays blocked
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h33});
    sb.push_back({1'b1, 8'h22});
    fork
      begin
        send(0, 8'h11, 1'b0, t1);
        wait_neg(FRAME + 40);
        check("stall_grant", 32'(grant), 32'd1);
        check("stall_tx", 32'(uart_tx), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_rdy1", 32'(req1_ready), 32'd0);
        check("stall_rdy0", 32'(req0_ready), 32'd1);
        send(0, 8'h33, 1'b1, t2);
      end
      begin
        wait_neg(5);
        send(1, 8'h22, 1'b1, tb);
      end
    join
    check("stall_req1_xfer", 32'(tb - t2), 32'(FRAME + 2));
    wait_idle();

    // Reset during DATA bit 3, then 0xA5 intact
    send(0, 8'h5A, 1'b1, t1);
    wait_neg(4 * CPB + 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_tx", 32'(uart_tx), 32'd1);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    wait_neg(3);
    reset_n = 1'b1;
    sb.push_back({1'b0, 8'hA5});
    send(0, 8'hA5, 1'b1, t1);
    wait_idle();

`ifdef UART_TX_ARBITER_PARITY_EN
    sb.push_back({1'b0, 8'h07});
    sb.push_back({1'b0, 8'h03});
    send(0, 8'h07, 1'b1, t1);
    wait_idle();
    send(0, 8'h03, 1'b1, t1);
    wait_idle();
`endif

    wait_neg(20);
    check("frames_rx", 32'(frames_rx), 32'(NFRAMES));
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division), required >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a byte offered.
REQ-006 SHALL have ports req0_data / req1_data  input  8  offered byte.
REQ-007 SHALL have ports req0_last / req1_last  input  1  offered byte ends the message.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  byte accepted when valid and ready are both high at a rising edge.
REQ-009 SHALL have port grant  output  2  one-hot owner of the line, 00 when unowned.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high, LSB-first 8N1.

Function
REQ-012 SHALL implement states IDLE, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: if any reqN_valid is high, SHALL register grant at the next edge and go to LOAD. With both valid, grant goes to the requester named by the round-robin pointer.
REQ-014 LOAD: the owner's ready SHALL be high and the other ready low. On transfer, SHALL latch data and last, then go to START.
REQ-015 If the owner drops valid in LOAD, SHALL stay in LOAD holding grant; the lock is held until the byte flagged last has been sent.
REQ-016 START SHALL drive uart_tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive bits 0..7, each for CLKS_PER_BIT cycles; a 3-bit index counts the bits.
REQ-018 STOP SHALL drive uart_tx=1 for CLKS_PER_BIT cycles, then go to:
  - IDLE if latched last=1: grant cleared to 00, pointer set to the other requester.
  - LOAD otherwise.
REQ-019 Latency: with valid high before edge N in IDLE:
  - grant is valid after edge N;
  - transfer occurs at edge N+1;
  - uart_tx falls after edge N+1.
REQ-020 Inter-byte gap within a message SHALL be exactly one extra idle-high cycle (the LOAD cycle) when the next byte is already valid.
REQ-021 A non-owner's valid SHALL be ignored while grant is nonzero; its ready stays low.
REQ-022 ready SHALL be low in every state except LOAD.
REQ-023 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reload to 0 at each bit boundary, and never wrap mid-bit.
REQ-024 uart_tx SHALL be driven from a register, glitch-free.

Reset
REQ-025 When reset_n=0, SHALL asynchronously force:
  - state IDLE, uart_tx=1;
  - req0_ready=req1_ready=0, grant=00, busy=0;
  - pointer=req0, counters 0.
REQ-026 Reset asserted mid-byte SHALL abort the frame immediately; the line returns high and the partial byte is discarded.
REQ-027 After reset_n rises, the first arbitration SHALL occur on the first edge with any valid high.

Configuration
REQ-028 Macro UART_TX_ARBITER_PARITY_EN defined: SHALL insert PARITY state between DATA and STOP, driving the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 8E1, 11 bit periods.
REQ-029 Macro undefined: PARITY state and logic SHALL be absent; frame is 8N1, 10 bit periods.

Verification (CLK_HZ=16, BAUD=1, so CLKS_PER_BIT=16)
REQ-030 Single byte: req0 sends 0x55 with last=1.
  - ready pulses one cycle; tx shows 0,1,0,1,0,1,0,1,0,1, each 16 cycles.
  - Back to IDLE, grant=00, busy=0, at 161 cycles after transfer.
REQ-031 Contention: both valid in the same cycle after reset.
  - req0 is granted first.
  - After req0's last byte, req1 is granted; next tie goes to req0.
REQ-032 Lock: req0 sends a 3-byte message 0x01,0x02,0x03(last) while req1 is continuously valid.
  - req1_ready stays 0 until 0x03's stop bit ends.
  - Gaps between req0 bytes are 1 cycle.
REQ-033 Stall: req0 drops valid after byte 1 of a 2-byte message.
  - grant stays 01, tx stays high, req1 is blocked.
  - req0 resumes 40 cycles later and its byte is sent normally.
REQ-034 Reset mid-frame: reset_n=0 during DATA bit 3.
  - tx=1, grant=00, busy=0 asynchronously.
  - After release, a new byte 0xA5 is sent intact.
REQ-035 With UART_TX_ARBITER_PARITY_EN: 0x07 produces parity bit 1 and 0x03 produces parity bit 0; frame length is 176 cycles.
